// File: rtl/aes_key_we_seq.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_we_seq
// Description : Sequences masked key-share word writes into one-hot write
//               enables, tracks written words and signals when a key is full.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_we_seq #(
    parameter int NumShares = 2,
    parameter int NumWords  = 8,
    parameter int DataWidth = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            wr_valid_i,
    output logic                            wr_ready_o,
    input  logic [$clog2(NumShares)-1:0]    wr_share_i,
    input  logic [$clog2(NumWords)-1:0]     wr_idx_i,
    input  logic [DataWidth-1:0]            wr_data_i,
    output logic [NumShares*NumWords-1:0]   key_init_we_o,
    output logic [DataWidth-1:0]            key_data_o,
    output logic [NumShares*NumWords-1:0]   written_o,
    output logic                            key_new_o,
    input  logic                            key_use_i,
    input  logic                            key_clear_i,
    output logic                            err_o
);

    localparam int c_num_total = NumShares * NumWords;
    localparam int c_flat_w    = (c_num_total > 1) ? $clog2(c_num_total) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FULL  = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_num_total-1:0]  r_we;
    logic [DataWidth-1:0]    r_data;
    logic [c_num_total-1:0]  r_written;
    logic                    r_err;

    logic                    w_accept;
    logic [c_flat_w-1:0]     w_flat_idx;
    logic [c_num_total-1:0]  w_onehot;
    logic [c_num_total-1:0]  w_written_upd;

    // Share-major flattening: bit = share*NumWords + idx
    assign w_flat_idx    = c_flat_w'(wr_share_i) * c_flat_w'(NumWords) + c_flat_w'(wr_idx_i);
    assign w_written_upd = r_written | w_onehot;

    always_comb begin
        w_onehot             = '0;
        w_onehot[w_flat_idx] = 1'b1;
    end

    always_comb begin
        wr_ready_o  = ((r_state == ST_IDLE) || (r_state == ST_LOAD)) && !key_clear_i;
        key_new_o   = (r_state == ST_FULL);
        w_accept    = wr_valid_i && wr_ready_o;
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_LOAD: begin
                if (w_accept) begin
                    w_state_nxt = (&w_written_upd) ? ST_FULL : ST_LOAD;
                end
            end
            ST_FULL: begin
                if (key_use_i) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // A wipe request overrides every other transition, including writes
        if (key_clear_i) begin
            w_state_nxt = ST_CLEAR;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_we      <= '0;
            r_data    <= '0;
            r_written <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt == ST_CLEAR) begin
                r_we      <= '0;
                r_data    <= '0;
                r_written <= '0;
            end else begin
                r_we <= w_accept ? w_onehot : '0;
                if (w_accept) begin
                    r_data    <= wr_data_i;
                    r_written <= w_written_upd;
                end
            end
            if (key_clear_i) begin
                r_err <= 1'b0;
            end else if (key_use_i && (r_state != ST_FULL)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign key_init_we_o = r_we;
    assign key_data_o    = r_data;
    assign written_o     = r_written;
    assign err_o         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_we_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_key_we_seq
// Description : Self-checking bench for aes_key_we_seq with a per-cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_we_seq;

    localparam int NS = 2;
    localparam int NW = 8;
    localparam int DW = 32;
    localparam int NT = NS * NW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [0:0]    wr_share = '0;
    logic [2:0]    wr_idx = '0;
    logic [DW-1:0] wr_data = '0;
    logic [NT-1:0] key_init_we;
    logic [DW-1:0] key_data;
    logic [NT-1:0] written;
    logic          key_new;
    logic          key_use = 1'b0;
    logic          key_clear = 1'b0;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    aes_key_we_seq #(.NumShares(NS), .NumWords(NW), .DataWidth(DW)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .wr_valid_i    (wr_valid),
        .wr_ready_o    (wr_ready),
        .wr_share_i    (wr_share),
        .wr_idx_i      (wr_idx),
        .wr_data_i     (wr_data),
        .key_init_we_o (key_init_we),
        .key_data_o    (key_data),
        .written_o     (written),
        .key_new_o     (key_new),
        .key_use_i     (key_use),
        .key_clear_i   (key_clear),
        .err_o         (err)
    );

    always #5 clk = ~clk;

    // Model: key words as a flat set of flags, a phase label, last accepted word
    typedef enum int {P_IDLE, P_LOAD, P_FULL, P_CLEAR} phase_t;
    phase_t        m_phase;
    logic [NT-1:0] m_written;
    logic [NT-1:0] m_we;
    logic [DW-1:0] m_data;
    logic          m_err;
    logic          m_ready;
    logic          m_acc;
    int            m_k;
    logic [NT-1:0] m_onehot;

    assign m_ready = ((m_phase == P_IDLE) || (m_phase == P_LOAD)) && !key_clear;
    assign m_acc   = wr_valid && m_ready;
    assign m_k     = int'(wr_share) * NW + int'(wr_idx);

    always_comb begin
        m_onehot      = '0;
        m_onehot[m_k] = 1'b1;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase   <= P_IDLE;
            m_written <= '0;
            m_we      <= '0;
            m_data    <= '0;
            m_err     <= 1'b0;
        end else if (key_clear) begin
            m_phase   <= P_CLEAR;
            m_written <= '0;
            m_we      <= '0;
            m_data    <= '0;
            m_err     <= 1'b0;
        end else begin
            m_we <= '0;
            if (key_use && m_phase != P_FULL) m_err <= 1'b1;
            if (m_phase == P_FULL) begin
                if (key_use) begin
                    m_phase   <= P_CLEAR;
                    m_written <= '0;
                    m_data    <= '0;
                end
            end else if (m_phase == P_CLEAR) begin
                m_phase <= P_IDLE;
            end else if (m_acc) begin
                m_we      <= m_onehot;
                m_data    <= wr_data;
                m_written <= m_written | m_onehot;
                m_phase   <= (&(m_written | m_onehot)) ? P_FULL : P_LOAD;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_we",      64'(key_init_we), 64'(m_we));
            check("cyc_data",    64'(key_data),    64'(m_data));
            check("cyc_written", 64'(written),     64'(m_written));
            check("cyc_new",     64'(key_new),     64'(m_phase == P_FULL));
            check("cyc_err",     64'(err),         64'(m_err));
            check("cyc_ready",   64'(wr_ready),    64'(m_ready));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drives one write that is sampled at the next edge
    task automatic wr(input int s, input int i, input logic [DW-1:0] d);
        wr_valid = 1'b1;
        wr_share = 1'(s);
        wr_idx   = 3'(i);
        wr_data  = d;
        cyc();
        wr_valid = 1'b0;
    endtask

    initial begin
        cyc();
        cyc();
        check("rst_we",      64'(key_init_we), 64'h0);
        check("rst_data",    64'(key_data),    64'h0);
        check("rst_written", 64'(written),     64'h0);
        check("rst_new",     64'(key_new),     64'h0);
        check("rst_err",     64'(err),         64'h0);
        check("rst_ready",   64'(wr_ready),    64'h1);
        rst = 1'b0;
        chk_en = 1'b1;
        cyc();

        // First write and a rewrite of the same word
        wr(0, 3, 32'hA5A5_0003);
        check("w03_we",      64'(key_init_we), 64'h0008);
        check("w03_data",    64'(key_data),    64'hA5A5_0003);
        check("w03_written", 64'(written),     64'h0008);
        check("w03_ready",   64'(wr_ready),    64'h1);
        cyc();
        check("hold_data",   64'(key_data),    64'hA5A5_0003);
        check("hold_we",     64'(key_init_we), 64'h0);
        wr(0, 3, 32'h1111_2222);
        check("rewr_we",     64'(key_init_we), 64'h0008);
        check("rewr_err",    64'(err),         64'h0);

        // Misplaced key use in LOAD, then wipe
        key_use = 1'b1;
        cyc();
        key_use = 1'b0;
        check("use_load_err", 64'(err), 64'h1);
        wr(1, 0, 32'h0000_0100);
        check("after_err_we",      64'(key_init_we), 64'h0100);
        check("after_err_written", 64'(written),     64'h0108);
        key_clear = 1'b1;
        #1;
        check("clr_ready", 64'(wr_ready), 64'h0);
        cyc();
        key_clear = 1'b0;
        check("clr_err",     64'(err),     64'h0);
        check("clr_written", 64'(written), 64'h0);
        check("clr_data",    64'(key_data), 64'h0);
        cyc();

        // Write colliding with a wipe
        wr(0, 1, 32'h0000_0001);
        wr_valid = 1'b1;
        wr_share = 1'b0;
        wr_idx   = 3'd2;
        key_clear = 1'b1;
        #1;
        check("coll_ready", 64'(wr_ready), 64'h0);
        cyc();
        wr_valid = 1'b0;
        key_clear = 1'b0;
        check("coll_we",      64'(key_init_we), 64'h0);
        check("coll_written", 64'(written),     64'h0);
        cyc();

        // Fill all sixteen words back-to-back
        wr_valid = 1'b1;
        for (int i = 0; i < NT; i++) begin
            wr_share = 1'(i / NW);
            wr_idx   = 3'(i % NW);
            wr_data  = 32'hC0DE_0000 + 32'(i);
            cyc();
            check("fill_we",   64'(key_init_we), 64'(16'h1 << i));
            check("fill_data", 64'(key_data),    64'(32'hC0DE_0000 + 32'(i)));
            check("fill_new",  64'(key_new),     64'(i == NT - 1));
        end
        check("full_written", 64'(written),  64'hFFFF);
        check("full_ready",   64'(wr_ready), 64'h0);
        // Write attempt while full is dropped
        cyc();
        wr_valid = 1'b0;
        check("full_drop_we", 64'(key_init_we), 64'h0);
        check("full_drop_written", 64'(written), 64'hFFFF);

        // Consume the key
        key_use = 1'b1;
        cyc();
        key_use = 1'b0;
        check("use_we",      64'(key_init_we), 64'h0);
        check("use_data",    64'(key_data),    64'h0);
        check("use_written", 64'(written),     64'h0);
        check("use_new",     64'(key_new),     64'h0);
        check("use_err",     64'(err),         64'h0);
        check("use_ready",   64'(wr_ready),    64'h0);
        cyc();
        check("idle_ready",  64'(wr_ready),    64'h1);

        // Reset in the middle of a load
        for (int i = 0; i < 5; i++) wr(0, i, 32'hBEEF_0000 + 32'(i));
        check("pre_rst_written", 64'(written), 64'h001F);
        rst = 1'b1;
        #1;
        check("mrst_we",      64'(key_init_we), 64'h0);
        check("mrst_data",    64'(key_data),    64'h0);
        check("mrst_written", 64'(written),     64'h0);
        check("mrst_ready",   64'(wr_ready),    64'h1);
        cyc();
        rst = 1'b0;
        cyc();
        check("post_rst_we", 64'(key_init_we), 64'h0);
        wr(1, 7, 32'h7777_0017);
        check("s1i7_we",   64'(key_init_we), 64'h8000);
        check("s1i7_data", 64'(key_data),    64'h7777_0017);

        cyc();
        cyc();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
